// File: rtl/debounce_edge_detect.sv
// Consecutive-sample debouncer with registered rise/fall pulses and a busy flag.
// Optional accepted-edge counter port edge_cnt, enabled by defining DBE_EDGE_COUNT_EN.
module debounce_edge_detect #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4,
    parameter int EC_W          = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    output logic            level,
    output logic            rise,
    output logic            fall,
    output logic            busy
`ifdef DBE_EDGE_COUNT_EN
    ,
    output logic [EC_W-1:0] edge_cnt
`endif
);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_W) - 1 || EC_W < 1) begin : g_param_check
        $error("debounce_edge_detect: STABLE_CYCLES must fit in CNT_W bits and EC_W must be >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any sample matching the current level drops back to IDLE with a cleared count.
    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (din != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = din;
                rise_d  = din;
                fall_d  = ~din;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = PEND;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign busy  = (state_q == PEND);

`ifdef DBE_EDGE_COUNT_EN
    logic [EC_W-1:0] edge_cnt_q, edge_cnt_d;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (rise_d | fall_d) begin
            edge_cnt_d = edge_cnt_q + EC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

endmodule
